// File: rtl/sat_dot_accumulator.sv
// sat_dot_accumulator
//   Streaming signed accumulator that sits behind the PE multiplier array. It sums a
//   programmable number of signed products with P-bit saturating addition. Each batch
//   yields one clamped dot-product result, which it hands over on a valid/ready handshake.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   len        terms per batch (0 treated as 1), sampled on the first accepted beat
//   in_valid   upstream product valid
//   in_ready   block can accept a product this cycle
//   in_data    signed product, IN_W bits
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   signed saturated sum, P bits
//   out_sat    at least one add in this batch clamped
//   busy       high while accumulating or presenting a result
module sat_dot_accumulator #(
  parameter int unsigned P     = 32,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned K_MAX = 256,
  parameter int unsigned CNT_W = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CNT_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [P-1:0]            out_data,
  output logic                    out_sat,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                 state;
  logic signed [P-1:0]    acc;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       len_q;
  logic                   sat_q;

  logic signed [P-1:0]    ext;
  logic signed [P-1:0]    sum_raw;
  logic signed [P-1:0]    sum_sat;
  logic                   ovf_pos;
  logic                   ovf_neg;
  logic [CNT_W-1:0]       len_eff;
  logic [CNT_W-1:0]       cnt_nxt;

  localparam logic [P-1:0] SatMax = {1'b0, {(P-1){1'b1}}};
  localparam logic [P-1:0] SatMin = {1'b1, {(P-1){1'b0}}};

  // Size cast of a signed operand sign-extends; also works when IN_W == P.
  assign ext     = P'($signed(in_data));
  assign sum_raw = acc + ext;

  // Overflow only possible when both operands share a sign and the sum flips it.
  assign ovf_pos = !acc[P-1] && !ext[P-1] &&  sum_raw[P-1];
  assign ovf_neg =  acc[P-1] &&  ext[P-1] && !sum_raw[P-1];

  always_comb begin
    sum_sat = sum_raw;
    if (ovf_pos) begin
      sum_sat = SatMax;
    end else if (ovf_neg) begin
      sum_sat = SatMin;
    end
  end

  assign len_eff = (len == '0) ? CNT_W'(1) : len;
  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= StIdle;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            // First term loads directly; nothing to add to, so no clamp possible.
            acc   <= ext;
            cnt   <= CNT_W'(1);
            sat_q <= 1'b0;
            len_q <= len_eff;
            state <= (len_eff == CNT_W'(1)) ? StOut : StAcc;
          end
        end
        StAcc: begin
          if (in_valid) begin
            acc <= sum_sat;
            cnt <= cnt_nxt;
            if (ovf_pos || ovf_neg) begin
              sat_q <= 1'b1;
            end
            if (cnt_nxt == len_q) begin
              state <= StOut;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // All outputs decode directly from registered state, so they are glitch-free.
  assign in_ready  = (state != StOut);
  assign out_valid = (state == StOut);
  assign busy      = (state != StIdle);
  assign out_data  = acc;
  assign out_sat   = sat_q;

`ifndef SYNTHESIS
  logic           hold_q;
  logic [P-1:0]   data_hold_q;
  logic           sat_hold_q;

  always_ff @(posedge clk) begin
    hold_q      <= rst_n && out_valid && !out_ready;
    data_hold_q <= out_data;
    sat_hold_q  <= out_sat;
    if (rst_n && hold_q) begin
      assert (out_data == data_hold_q && out_sat == sat_hold_q);
    end
    if (rst_n) begin
      assert (cnt <= len_q);
    end
    if (rst_n && state == StIdle && in_valid) begin
      assert (32'(len) <= K_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_sat_dot_accumulator.sv
// tb_sat_dot_accumulator
//   Directed bench for sat_dot_accumulator. Two instances share one stimulus stream:
//   dut_a is built with P=32 and dut_b with P=16, so the 16-bit instance exercises clamping.
//   Expected values are hand-computed constants.
module tb_sat_dot_accumulator;

  logic        clk;
  logic        rst_n;
  logic [8:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
  logic [15:0] out_data_b;

  int n_checks = 0;
  int n_errors = 0;

  sat_dot_accumulator #(.P(32), .IN_W(16), .K_MAX(256)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_sat   (out_sat_a),
    .busy      (busy_a)
  );

  sat_dot_accumulator #(.P(16), .IN_W(16), .K_MAX(256)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_sat   (out_sat_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat for exactly one rising edge; inputs change 1 time unit after the edge.
  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid_a, 0);
    check_eq("rst_out_data",  out_data_a, 0);
    check_eq("rst_out_sat",   out_sat_a, 0);
    check_eq("rst_busy",      busy_a, 0);
    check_eq("rst_in_ready",  in_ready_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Batch of 4 back-to-back: 3 - 5 + 100 + 7 = 105.
    len = 9'd4;
    beat(16'd3);
    check_eq("t1_busy_acc", busy_a, 1);
    beat(16'hFFFB);
    beat(16'd100);
    check_eq("t1_no_valid_early", out_valid_a, 0);
    beat(16'd7);
    check_eq("t1_out_valid", out_valid_a, 1);
    check_eq("t1_out_data",  out_data_a, 105);
    check_eq("t1_out_sat",   out_sat_a, 0);
    check_eq("t1_in_ready",  in_ready_a, 0);
    check_eq("t1_b_out_data", out_data_b, 105);
    handshake();
    check_eq("t1_valid_drop", out_valid_a, 0);
    check_eq("t1_idle_busy",  busy_a, 0);

    // 3 x 32767: P=16 clamps at step 2 and stays; P=32 reaches 98301.
    len = 9'd3;
    beat(16'h7FFF);
    beat(16'h7FFF);
    beat(16'h7FFF);
    check_eq("t2_b_out_data", out_data_b, 16'h7FFF);
    check_eq("t2_b_out_sat",  out_sat_b, 1);
    check_eq("t2_a_out_data", out_data_a, 98301);
    check_eq("t2_a_out_sat",  out_sat_a, 0);
    handshake();

    // -32768, -1, 5: P=16 clamps to -32768 then continues to -32763.
    len = 9'd3;
    beat(16'h8000);
    beat(16'hFFFF);
    beat(16'd5);
    check_eq("t3_b_out_data", out_data_b, 16'h8005);
    check_eq("t3_b_out_sat",  out_sat_b, 1);
    check_eq("t3_a_out_data", out_data_a, 32'hFFFF8004);
    check_eq("t3_a_out_sat",  out_sat_a, 0);
    handshake();

    // len=0 and len=1 both end after a single beat of -9.
    for (int l = 0; l < 2; l++) begin
      len = 9'(l);
      beat(16'hFFF7);
      check_eq("t4_out_valid", out_valid_a, 1);
      check_eq("t4_out_data",  out_data_a, 32'hFFFFFFF7);
      check_eq("t4_out_sat",   out_sat_a, 0);
      check_eq("t4_b_out_data", out_data_b, 16'hFFF7);
      handshake();
    end

    // Backpressure: result 3 held for 5 cycles while a pending beat waits.
    len = 9'd2;
    beat(16'd1);
    beat(16'd2);
    len      = 9'd1;
    in_valid = 1'b1;
    in_data  = 16'd1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_valid", out_valid_a, 1);
      check_eq("t5_hold_data",  out_data_a, 3);
      check_eq("t5_hold_ready", in_ready_a, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("t5_after_hs_valid", out_valid_a, 0);
    check_eq("t5_after_hs_ready", in_ready_a, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("t5_next_valid", out_valid_a, 1);
    check_eq("t5_next_data",  out_data_a, 1);
    handshake();

    // Reset mid-batch, then a fresh 10 + 20 batch.
    len = 9'd4;
    beat(16'd50);
    beat(16'd60);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("t6_rst_busy", busy_a, 0);
    check_eq("t6_rst_data", out_data_a, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_no_output", out_valid_a, 0);
    len = 9'd2;
    beat(16'd10);
    beat(16'd20);
    check_eq("t6_out_valid", out_valid_a, 1);
    check_eq("t6_out_data",  out_data_a, 30);
    check_eq("t6_out_sat",   out_sat_a, 0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sat_dot_accumulator.md
Name: sat_dot_accumulator

Overview:
- Streaming signed accumulator placed directly downstream of the PE multiplier array.
- Consumes a stream of signed products and sums a programmable number of terms using P-bit saturating signed addition.
- Emits one clamped dot-product result per batch over a valid/ready handshake to the output writeback stage.

Parameters:
P, 32, accumulator and result width in bits (signed two's complement)
IN_W, 16, input product width in bits (signed); IN_W <= P is required
K_MAX, 256, maximum number of terms per batch
CNT_W, $clog2(K_MAX+1), width of the length input and of the internal term counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
len  input  CNT_W  terms per batch; sampled only on the first accepted beat of a batch
in_valid  input  1  upstream product valid
in_ready  output  1  block can accept a product this cycle
in_data  input  IN_W  signed product
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  P  signed saturated sum
out_sat  output  1  at least one add in this batch clamped
busy  output  1  high in ACC or OUT state

Behaviour:
- Interface: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset (rst_n low at a clock edge):
  - state=IDLE; acc=0; cnt=0; len_q=0; sat_q=0.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - Applies mid-batch too: partial sum discarded, no result emitted.
- Beat accept: in_valid && in_ready at a rising edge.
- Operand preparation: in_data is sign-extended from IN_W to P bits.
- Saturating add: sum = acc + ext, computed modulo 2^P.
  - Both operands have MSB 0 and sum MSB 1: clamp to 2^(P-1)-1.
  - Both operands have MSB 1 and sum MSB 0: clamp to -2^(P-1).
  - Every clamp sets sat_q.
  - Saturation is per step and not sticky: later terms add to the clamped value.
- IDLE: in_ready=1, out_valid=0.
  - On accept: acc=ext(in_data) (no add, no clamp); cnt=1; sat_q=0.
  - len_q=len, with len=0 treated as 1.
  - If effective len==1, go to OUT; else go to ACC.
- ACC: in_ready=1.
  - On accept: acc=sat_add(acc, ext(in_data)); cnt=cnt+1.
  - When the new cnt==len_q, go to OUT.
  - No accept: hold all state, no timeout.
- OUT: in_ready=0, out_valid=1, out_data=acc, out_sat=sat_q.
  - Values are held stable until handshake.
  - On out_ready, go to IDLE next cycle; out_valid drops the cycle after the handshake.
- Latency and throughput:
  - out_valid rises the cycle after the last beat is accepted.
  - Minimum batch period is len+1 cycles (one bubble in OUT).
- Backpressure: out_ready low holds OUT indefinitely. in_ready stays 0 throughout OUT, so no product is lost.
- out_ready while not in OUT: ignored.
- len changing mid-batch: ignored; len_q governs.
- in_data while in_ready=0: ignored.
- busy = (state != IDLE).
- Assertions (simulation only):
  - out_data/out_sat stable while out_valid && !out_ready.
  - cnt never exceeds len_q.
  - len > K_MAX never applied.

Test Plan:
- P=32, IN_W=16, len=4, inputs 3, -5, 100, 7, all back-to-back -> out_valid one cycle after 4th accept; out_data=105, out_sat=0; in_ready=0 while in OUT.
- len=3, inputs 32767 each, P=16 build -> step 2 clamps to 32767, step 3 stays 32767; out_data=32767, out_sat=1.
- P=16, len=3, inputs -32768, -1, 5 -> clamp to -32768, then -32763; out_sat=1 (non-sticky value, sticky flag).
- len=0 and len=1, single input -9 -> OUT directly after one accept; out_data=-9 (0xFFFFFFF7), out_sat=0.
- len=2, out_ready held low 5 cycles after result -> out_valid, out_data and in_ready=0 held all 5 cycles; in_valid asserted with data 1 during stall is not consumed and is accepted as the next batch's first beat after the handshake.
- rst_n low for one cycle after 2 of 4 beats, then a fresh len=2 batch of 10, 20 -> no output from the aborted batch; next result out_data=30, out_sat=0.
